// File: rtl/uart_img_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_img_loader_pkg
// Description : Shared FSM encodings and frame marker for the UART image loader.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_img_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_PIXELS = 2'd1;
  localparam state_t S_CHECK  = 2'd2;

  localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hAA;

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// ============================================================================
// Module      : loader_timeout
// Description : Inter-byte idle counter; flags expiry when TIMEOUT is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module loader_timeout #(
  parameter int unsigned  TIMEOUT = 1_200_000,
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_max  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A byte arriving in the expiry cycle wins over the timeout.
  assign expired = enable && !clear && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_img_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_img_loader
// Description : Receives SOF + pixel bytes + XOR checksum, writes framebuffer.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_img_loader
  import uart_img_loader_pkg::*;
#(
  parameter int unsigned  IMG_W    = 64,
  parameter int unsigned  IMG_H    = 48,
  parameter logic [7:0]   SOF_BYTE = SOF_BYTE_DEFAULT,
  parameter int unsigned  TIMEOUT  = 1_200_000,
  localparam int unsigned NPIX     = IMG_W * IMG_H,
  localparam int unsigned ADDR_W   = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_rdy,
  input  logic [7:0]        data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_ok,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] c_last_pix = ADDR_W'(NPIX - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic [7:0]        r_xor;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_frame_ok;
  logic              r_frame_err;

  logic              w_sof;
  logic              w_wr_en;
  logic              w_frame_ok;
  logic              w_frame_err;
  logic              w_to_clear;
  logic              w_to_en;
  logic              w_to_expired;

  assign w_sof      = (r_state == S_IDLE) && data_rdy && (data == SOF_BYTE);
  assign w_to_clear = data_rdy || (r_state == S_IDLE);
  assign w_to_en    = (r_state == S_PIXELS) || (r_state == S_CHECK);

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_to_clear),
    .enable  (w_to_en),
    .expired (w_to_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sof) begin
          w_next_state = S_PIXELS;
        end
      end
      S_PIXELS: begin
        if (data_rdy) begin
          if (r_pix_cnt == c_last_pix) begin
            w_next_state = S_CHECK;
          end
        end else if (w_to_expired) begin
          w_next_state = S_IDLE;
        end
      end
      S_CHECK: begin
        if (data_rdy || w_to_expired) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_en     = (r_state == S_PIXELS) && data_rdy;
    w_frame_ok  = (r_state == S_CHECK) && data_rdy && (data == r_xor);
    w_frame_err = ((r_state == S_CHECK) && data_rdy && (data != r_xor)) ||
                  ((r_state != S_IDLE) && w_to_expired);
  end

  // Pixel address counter, running checksum and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_cnt   <= '0;
      r_xor       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= w_wr_en;
      r_frame_ok  <= w_frame_ok;
      r_frame_err <= w_frame_err;
      if (w_sof) begin
        r_pix_cnt <= '0;
        r_xor     <= '0;
      end else if (w_wr_en) begin
        r_wr_addr <= r_pix_cnt;
        r_wr_data <= data;
        r_xor     <= r_xor ^ data;
        r_pix_cnt <= (r_pix_cnt == c_last_pix) ? '0 : r_pix_cnt + 1'b1;
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = (r_state == S_PIXELS) || (r_state == S_CHECK);
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire
